// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-state data-memory responder with single-cycle ready; MISALIGN_CHECK_EN adds err_o
module data_mem_responder #(
  parameter int AW          = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] datain_i,
  output logic        ready_o,
  output logic [31:0] dataout_o,
  output logic        busy_o
`ifdef MISALIGN_CHECK_EN
  ,
  output logic        err_o
`endif
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            wr_q, mis_q, mis_d, rd_wr, rd_mis, unused_addr;
  logic [AW-1:0]   idx_q, rd_idx;
  logic [31:0]     wdata_q, dataout_q;
  logic [31:0]     mem [2**AW];
`ifdef MISALIGN_CHECK_EN
  assign mis_d = |addr_i[1:0];
  assign err_o = ready_o & mis_q;
`else
  assign mis_d = 1'b0;
`endif
  assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};
  // with zero wait states RESP follows acceptance directly, so the read uses the live request
  assign rd_idx    = (state_q == IDLE) ? addr_i[AW+1:2] : idx_q;
  assign rd_wr     = (state_q == IDLE) ? write_i : wr_q;
  assign rd_mis    = (state_q == IDLE) ? mis_d : mis_q;
  assign ready_o   = state_q == RESP;
  assign busy_o    = state_q != IDLE;
  assign dataout_o = dataout_q;
  // next-state and wait counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (req_i) begin
        state_d = (WAIT_STATES == 0) ? RESP : WAIT;
        cnt_d   = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
      end
      WAIT: begin
        state_d = (cnt_q == 4'd0) ? RESP : WAIT;
        cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state, captured request and load data register; dataout is loaded on entry to RESP
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      mis_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      dataout_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req_i) begin
        wr_q    <= write_i;
        mis_q   <= mis_d;
        idx_q   <= addr_i[AW+1:2];
        wdata_q <= datain_i;
      end
      if (state_d == RESP && !rd_wr && !rd_mis) dataout_q <= mem[rd_idx];
    end
  end
  // store commits on the RESP edge; RAM is never cleared by reset
  always_ff @(posedge clk_i) begin
    if (state_q == RESP && wr_q && !mis_q) mem[idx_q] <= wdata_q;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: table-driven scoreboard bench for two responder configurations
module tb_data_mem_responder;
  localparam int W0 = 2;
  localparam int W1 = 0;
  typedef struct { int d; bit w; logic [31:0] a; logic [31:0] din; logic [31:0] exp; } vec_t;
  typedef struct { int d; logic [31:0] exp; bit err; } sb_t;
  logic        clk = 0, rst_n = 0;
  logic        req[2], wr[2], ready[2], busy[2];
  logic [31:0] addr[2], din[2], dout[2];
`ifdef MISALIGN_CHECK_EN
  logic        err[2];
`endif
  sb_t         sb[$];
  vec_t        tbl[$];
  logic [31:0] last[2];
  time         rt[2];
  int          checks = 0, fails = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.AW(4), .WAIT_STATES(W0)) u_w2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .write_i(wr[0]), .addr_i(addr[0]),
    .datain_i(din[0]), .ready_o(ready[0]), .dataout_o(dout[0]), .busy_o(busy[0])
`ifdef MISALIGN_CHECK_EN
    , .err_o(err[0])
`endif
  );
  data_mem_responder #(.AW(4), .WAIT_STATES(W1)) u_w0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .write_i(wr[1]), .addr_i(addr[1]),
    .datain_i(din[1]), .ready_o(ready[1]), .dataout_o(dout[1]), .busy_o(busy[1])
`ifdef MISALIGN_CHECK_EN
    , .err_o(err[1])
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive_start(input int d, input bit w, input logic [31:0] a,
                             input logic [31:0] dv, input logic [31:0] exp, input bit hold);
    sb_t e;
    @(negedge clk);
    req[d] = 1; wr[d] = w; addr[d] = a; din[d] = dv;
    @(posedge clk);
    e.d = d; e.exp = w ? last[d] : exp; e.err = |a[1:0];
    sb.push_back(e);
    #1;
    chk("busy_after_accept", 32'(busy[d]), 1);
    if (!hold) begin
      req[d] = 0; wr[d] = ~w; addr[d] = ~a; din[d] = ~dv;
    end
  endtask

  task automatic wait_resp(input int d, input bit drop);
    int  n = 0;
    sb_t e;
    @(negedge clk);
    while (!ready[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (drop) req[d] = 0;
    e = sb.pop_front();
    if (!ready[d]) chk("ready_timeout", 32'(ready[d]), 1);
    else begin
      chk("latency", n, (d == 0) ? W0 : W1);
      chk("dataout", dout[d], e.exp);
`ifdef MISALIGN_CHECK_EN
      chk("err", 32'(err[d]), 32'(e.err));
`endif
      rt[d] = $time;
      last[d] = e.exp;
    end
    @(negedge clk);
    chk("ready_single_pulse", 32'(ready[d]), 0);
    chk("busy_idle", 32'(busy[d]), 0);
  endtask

  task automatic txn(input int d, input bit w, input logic [31:0] a,
                     input logic [31:0] dv, input logic [31:0] exp);
    drive_start(d, w, a, dv, exp, 0);
    wait_resp(d, 1);
  endtask

  initial begin
    int pulses;
    time t1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 0; wr[i] = 0; addr[i] = 0; din[i] = 0; last[i] = 0; rt[i] = 0;
    end
    tbl.push_back('{0, 1, 32'h40, 32'hDEADBEEF, 32'h0});
    tbl.push_back('{0, 0, 32'h40, 32'h0, 32'hDEADBEEF});
    tbl.push_back('{0, 1, 32'h10, 32'h0BADF00D, 32'h0});
    tbl.push_back('{0, 1, 32'h08, 32'h11111111, 32'h0});
    tbl.push_back('{0, 1, 32'h0C, 32'h22222222, 32'h0});
    tbl.push_back('{0, 0, 32'h10, 32'h0, 32'h0BADF00D});
    tbl.push_back('{0, 1, 32'h40, 32'h12345678, 32'h0});
    tbl.push_back('{0, 0, 32'h00, 32'h0, 32'h12345678});
    tbl.push_back('{0, 1, 32'h20, 32'hCAFEF00D, 32'h0});
    tbl.push_back('{0, 0, 32'h20, 32'h0, 32'hCAFEF00D});
    tbl.push_back('{0, 0, 32'hFFFF_FF4C, 32'h0, 32'h22222222});
    tbl.push_back('{1, 1, 32'h00, 32'hA5A5A5A5, 32'h0});
    tbl.push_back('{1, 1, 32'h04, 32'h5A5A5A5A, 32'h0});
    tbl.push_back('{1, 0, 32'h04, 32'h0, 32'h5A5A5A5A});
    tbl.push_back('{1, 0, 32'h00, 32'h0, 32'hA5A5A5A5});
    #2;
    for (int i = 0; i < 2; i++) begin
      chk("reset_ready", 32'(ready[i]), 0);
      chk("reset_busy", 32'(busy[i]), 0);
      chk("reset_dataout", dout[i], 0);
    end
    @(negedge clk);
    rst_n = 1;
    foreach (tbl[i]) txn(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].din, tbl[i].exp);
    // async reset during WAIT aborts a pending store
    drive_start(0, 1, 32'h10, 32'hAAAA5555, 32'h0, 0);
    @(negedge clk);
    chk("busy_mid_wait", 32'(busy[0]), 1);
    #2 rst_n = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("abort_ready", 32'(ready[i]), 0);
      chk("abort_busy", 32'(busy[i]), 0);
      chk("abort_dataout", dout[i], 0);
      last[i] = 0;
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (ready[0]) pulses++;
    end
    chk("abort_no_ready", pulses, 0);
    txn(0, 0, 32'h10, 32'h0, 32'h0BADF00D);
    // req held with changing addr while busy: only the first is serviced
    drive_start(0, 0, 32'h08, 32'h0, 32'h11111111, 1);
    addr[0] = 32'h0C;
    wait_resp(0, 1);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (ready[0]) pulses++;
    end
    chk("busy_drop_no_extra_ready", pulses, 0);
    // zero-wait back-to-back loads, one every two cycles
    drive_start(1, 0, 32'h00, 32'h0, 32'hA5A5A5A5, 1);
    wait_resp(1, 0);
    t1 = rt[1];
    addr[1] = 32'h04;
    @(posedge clk);
    sb.push_back('{1, 32'h5A5A5A5A, 1'b0});
    wait_resp(1, 1);
    chk("back_to_back_spacing", 32'(rt[1] - t1), 20);
`ifdef MISALIGN_CHECK_EN
    txn(0, 1, 32'h22, 32'h1, 32'h0);
    txn(0, 0, 32'h20, 32'h0, 32'hCAFEF00D);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
